// File: rtl/modexp.sv
// Sequential modular exponentiator (right-to-left square-and-multiply, bit-serial mulmod).
// Optional feature macro: MODEXP_EARLY_EXIT_EN stops the exponent scan once no set bits remain.
module modexp #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             finished,
    output logic [WIDTH-1:0] result,
    output logic             error
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, LOAD, MUL, SQR, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] m, r, b, e, acc, ysh;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    bitcnt;
    logic             err;

    logic [WIDTH:0]   m_ext, dbl, dbl_red, sum;
    logic [WIDTH-1:0] step;
    logic             last_step;

    // One interleaved shift-add step: acc stays < m, so each intermediate stays < 2m.
    always_comb begin
        m_ext     = {1'b0, m};
        dbl       = {acc, 1'b0};
        dbl_red   = (dbl >= m_ext) ? dbl - m_ext : dbl;
        sum       = dbl_red + {1'b0, (state == MUL) ? r : b};
        step      = dbl_red[WIDTH-1:0];
        if (ysh[WIDTH-1]) begin
            step = (sum >= m_ext) ? WIDTH'(sum - m_ext) : sum[WIDTH-1:0];
        end
        last_step = (cnt == CW'(WIDTH - 1));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            m        <= '0;
            r        <= '0;
            b        <= '0;
            e        <= '0;
            acc      <= '0;
            ysh      <= '0;
            cnt      <= '0;
            bitcnt   <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
            finished <= 1'b0;
            result   <= '0;
            error    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    finished <= 1'b0;
                    if (start) begin
                        m     <= modulus;
                        b     <= base;
                        e     <= exponent;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    acc <= '0;
                    cnt <= '0;
                    if (m < WIDTH'(2)) begin
                        r     <= '0;
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        r      <= WIDTH'(1);
                        b      <= b % m;
                        ysh    <= b % m;
                        bitcnt <= BW'(WIDTH);
                        err    <= 1'b0;
`ifdef MODEXP_EARLY_EXIT_EN
                        if (e == '0)
                            state <= DONE;
                        else
`endif
                        state <= e[0] ? MUL : SQR;
                    end
                end
                MUL: begin
                    acc <= step;
                    ysh <= ysh << 1;
                    cnt <= cnt + CW'(1);
                    if (last_step) begin
                        r   <= step;
                        acc <= '0;
                        cnt <= '0;
                        ysh <= b;
`ifdef MODEXP_EARLY_EXIT_EN
                        if ((e >> 1) == '0)
                            state <= DONE;
                        else
`endif
                        state <= SQR;
                    end
                end
                SQR: begin
                    acc <= step;
                    ysh <= ysh << 1;
                    cnt <= cnt + CW'(1);
                    if (last_step) begin
                        b      <= step;
                        e      <= e >> 1;
                        bitcnt <= bitcnt - BW'(1);
                        acc    <= '0;
                        cnt    <= '0;
                        ysh    <= step;
                        if (bitcnt == BW'(1))
                            state <= DONE;
                        else
                            state <= e[1] ? MUL : SQR;
                    end
                end
                DONE: begin
                    finished <= 1'b1;
                    busy     <= 1'b0;
                    result   <= r;
                    error    <= err;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modexp.sv
// Self-checking bench for modexp: directed cases plus random operands against a plain-arithmetic model.
// Latency expectations follow MODEXP_EARLY_EXIT_EN when the bench is compiled with it.
module tb_modexp;

    localparam int WIDTH = 32;
    localparam int LIMIT = 5000;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] base = '0, exponent = '0, modulus = '0;
    logic             busy, finished, error;
    logic [WIDTH-1:0] result;

    int checks = 0;
    int failures = 0;

    modexp #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start),
        .base(base), .exponent(exponent), .modulus(modulus),
        .busy(busy), .finished(finished), .result(result), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic longint unsigned ref_pow(longint unsigned bs, longint unsigned ex, longint unsigned md);
        longint unsigned acc_r, sq;
        if (md < 2) return 0;
        acc_r = 1 % md;
        sq    = bs % md;
        for (int i = 0; i < WIDTH; i++) begin
            if (ex[i]) acc_r = (acc_r * sq) % md;
            sq = (sq * sq) % md;
        end
        return acc_r;
    endfunction

    function automatic int ref_latency(longint unsigned ex, longint unsigned md);
        int pop, msb;
        if (md < 2) return 2;
        pop = 0;
        msb = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ex[i]) begin
                pop++;
                msb = i;
            end
        end
`ifdef MODEXP_EARLY_EXIT_EN
        if (ex == 0) return 2;
        return 2 + WIDTH * (pop + msb);
`else
        return 2 + WIDTH * (WIDTH + pop);
`endif
    endfunction

    task automatic launch(input logic [WIDTH-1:0] bs, input logic [WIDTH-1:0] ex, input logic [WIDTH-1:0] md);
        @(negedge clk);
        base     = bs;
        exponent = ex;
        modulus  = md;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_finished(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!finished && cycles < LIMIT);
    endtask

    // Launch, wait for the pulse and compare result, error, latency and handshake.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] bs, input logic [WIDTH-1:0] ex,
                          input logic [WIDTH-1:0] md, input logic [63:0] want);
        int cyc;
        launch(bs, ex, md);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        wait_finished(cyc);
        check({tag, "_result"}, 64'(result), want);
        check({tag, "_error"}, 64'(error), (md < 2) ? 64'd1 : 64'd0);
        check({tag, "_latency"}, 64'(cyc), 64'(ref_latency(ex, md)));
        check({tag, "_busy_at_fin"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_fin_pulse"}, 64'(finished), 64'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] rb, re, rm;
        int cyc;

        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_finished", 64'(finished), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_error", 64'(error), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("d357", 3, 5, 7, 64'd5);
        run_op("d3x5", 3, 1, 7, 64'd3);
        run_op("d4_13_497", 4, 13, 497, 64'd445);
        run_op("d2_31_max", 2, 31, 32'hFFFF_FFFB, 64'h8000_0000);
        run_op("d_exp0", 32'h1234_5678, 0, 7, 64'd1);
        run_op("d_mod0", 9, 3, 0, 64'd0);
        run_op("d_mod1", 9, 3, 1, 64'd0);
        run_op("d_big_base", 32'hFFFF_FFFF, 32'h8000_0001, 13, ref_pow(64'hFFFF_FFFF, 64'h8000_0001, 13));
        run_op("d_fermat", 12345, 32'hFFFF_FFFB - 2, 32'hFFFF_FFFB,
               ref_pow(12345, 64'hFFFF_FFFB - 2, 64'hFFFF_FFFB));

        // Abort in the middle of the first square.
        launch(3, 5, 7);
        repeat (40) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_finished", 64'(finished), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op("after_abort", 3, 5, 7, 64'd5);

        // Start held high through DONE: back-to-back ops, one pulse each.
        @(negedge clk);
        base = 3; exponent = 5; modulus = 7; start = 1'b1;
        @(posedge clk);
        #1;
        wait_finished(cyc);
        check("hold_first_result", 64'(result), 64'd5);
        check("hold_first_latency", 64'(cyc), 64'(ref_latency(5, 7)));
        @(posedge clk);
        #1;
        check("hold_second_busy", 64'(busy), 64'd1);
        check("hold_second_nofin", 64'(finished), 64'd0);
        start = 1'b0;
        wait_finished(cyc);
        check("hold_second_result", 64'(result), 64'd5);
        check("hold_second_latency", 64'(cyc), 64'(ref_latency(5, 7)));
        @(posedge clk);
        #1;
        check("hold_idle_busy", 64'(busy), 64'd0);
        check("hold_idle_fin", 64'(finished), 64'd0);

        // Random operands, including base >= modulus and small moduli.
        for (int i = 0; i < 10; i++) begin
            rb = $urandom;
            re = (i % 3 == 0) ? WIDTH'($urandom_range(0, 255)) : $urandom;
            rm = (i % 2 == 0) ? WIDTH'($urandom_range(0, 1000)) : ($urandom | 32'h8000_0000);
            run_op($sformatf("rnd%0d", i), rb, re, rm, ref_pow(64'(rb), 64'(re), 64'(rm)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
